// File: rtl/inst_fetch_stage_if.sv
// Instruction memory bus between the fetch stage (master) and instruction memory (slave).
// A request is held with a stable address until the memory acks it.
interface inst_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/inst_fetch_stage.sv
// MIPS IF stage: owns the PC and issues single-outstanding fetches.
// It loads the IF/ID register and parks one word in a holding buffer while the stage is stalled.
// A redirect or if_rst flushes the stage, and an in-flight fetch on the wrong path is discarded.
// Optional feature macro: IF_PERF_CNT_EN adds the perf_fetch_cnt/perf_wait_cnt counters.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_rst,
  input  logic                    if_en,
  output logic                    if_valid,
  input  logic                    pc_redirect,
  input  logic [31:0]             pc_target,
  inst_fetch_stage_if.master      imem,
  output logic [31:0]             inst_id,
  output logic [31:0]             pc_id,
  output logic [31:0]             pc4_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic [31:0] buf_pc;
  logic        discard, discard_nx;

  logic        req;
  logic        ack_in;
  logic        flush;
  logic [31:0] flush_pc;
  logic        take;
  logic        to_buf;
  logic        load_ifid;

  // Bus outputs. In WAIT the latched address is used, so a redirect that moves pc
  // cannot change the address of the request still in flight.
  always_comb begin
    req            = (state == S_REQ) || (state == S_WAIT);
    imem.imem_req  = req;
    imem.imem_addr = (state == S_WAIT) ? req_addr : pc;
  end

  // Control decode and FSM next-state.
  always_comb begin
    ack_in    = req && imem.imem_ack;
    flush     = if_rst || pc_redirect;
    flush_pc  = if_rst ? RESET_PC : pc_target;
    take      = ack_in && !discard && !flush;
    to_buf    = take && !if_en;
    load_ifid = !flush && if_en && (buf_valid || take);

    // A flush arms discard only if the request just issued goes unanswered this cycle.
    // An ack that coincides with the flush is simply dropped.
    discard_nx = flush ? (req && !imem.imem_ack) : (discard && !ack_in);

    state_nx = state;
    case (state)
      S_IDLE:         state_nx = S_REQ;
      S_REQ, S_WAIT:  state_nx = ack_in ? (to_buf ? S_HOLD : S_REQ) : S_WAIT;
      S_HOLD:         if (if_en) state_nx = S_REQ;
      default:        state_nx = S_IDLE;
    endcase
    if (flush) state_nx = discard_nx ? S_WAIT : S_REQ;
  end

  // FSM state and discard flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_nx;
      discard <= discard_nx;
    end
  end

  // PC, outstanding-request address and holding buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      buf_valid <= 1'b0;
      buf_data  <= '0;
      buf_pc    <= '0;
    end else begin
      if (state != S_WAIT) req_addr <= pc;
      if (flush)     pc <= flush_pc;
      else if (take) pc <= pc + 32'd4;
      if (flush) begin
        buf_valid <= 1'b0;
      end else if (to_buf) begin
        buf_valid <= 1'b1;
        buf_data  <= imem.imem_data;
        buf_pc    <= imem.imem_addr;
      end else if (if_en && buf_valid) begin
        buf_valid <= 1'b0;
      end
    end
  end

  // IF/ID register: the buffered word has priority over a fresh ack. With the stage
  // enabled and nothing to load, a bubble is inserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      inst_id  <= '0;
      pc_id    <= '0;
      pc4_id   <= '0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (if_en) begin
      if_valid <= load_ifid;
      if (buf_valid) begin
        inst_id <= buf_data;
        pc_id   <= buf_pc;
        pc4_id  <= buf_pc + 32'd4;
      end else if (take) begin
        inst_id <= imem.imem_data;
        pc_id   <= imem.imem_addr;
        pc4_id  <= imem.imem_addr + 32'd4;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (load_ifid)                 perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (req && !imem.imem_ack)     perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
